// File: rtl/dir_pkg.sv
// rtl/dir_pkg.sv - shared encodings for the directory controller and cache-block FSM
package dir_pkg;

  typedef enum logic [1:0] {
    UNCACHED  = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10
  } dir_state_e;

  typedef enum logic [1:0] {
    READ_MISS  = 2'b00,
    WRITE_MISS = 2'b01,
    WRITE_BACK = 2'b10,
    REQ_RSVD   = 2'b11
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DONE  = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/dir_entry_array.sv
// rtl/dir_entry_array.sv - directory entries {state, sharers} with one write port,
// a request lookup port (plus owner index) and a debug read port
module dir_entry_array
  import dir_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int NUM_BLOCKS = 4,
  localparam int NODE_W    = $clog2(NUM_NODES),
  localparam int BLK_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [BLK_W-1:0]     i_wr_block,
  input  logic [1:0]           i_wr_state,
  input  logic [NUM_NODES-1:0] i_wr_sharers,
  input  logic [BLK_W-1:0]     i_rd_block,
  output logic [1:0]           o_rd_state,
  output logic [NUM_NODES-1:0] o_rd_sharers,
  output logic [NODE_W-1:0]    o_rd_owner,
  input  logic [BLK_W-1:0]     i_dbg_block,
  output logic [1:0]           o_dbg_state,
  output logic [NUM_NODES-1:0] o_dbg_sharers
);

  logic [1:0]           r_state   [NUM_BLOCKS];
  logic [NUM_NODES-1:0] r_sharers [NUM_BLOCKS];

  // Only meaningful when exactly one bit is set (Exclusive entries).
  function automatic logic [NODE_W-1:0] onehot_to_idx(input logic [NUM_NODES-1:0] v);
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (v[i]) onehot_to_idx = NODE_W'(i);
    end
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_state[i]   <= UNCACHED;
        r_sharers[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_state[i_wr_block]   <= i_wr_state;
      r_sharers[i_wr_block] <= i_wr_sharers;
    end
  end

  assign o_rd_state    = r_state[i_rd_block];
  assign o_rd_sharers  = r_sharers[i_rd_block];
  assign o_rd_owner    = onehot_to_idx(r_sharers[i_rd_block]);
  assign o_dbg_state   = r_state[i_dbg_block];
  assign o_dbg_sharers = r_sharers[i_dbg_block];

endmodule

// File: rtl/dir_controller.sv
// rtl/dir_controller.sv - MSI directory controller: one request at a time,
// issues fetch / invalidate / data-value-reply messages
module dir_controller
  import dir_pkg::*;
#(
  parameter int NUM_NODES  = 4,
  parameter int NUM_BLOCKS = 4,
  localparam int NODE_W    = $clog2(NUM_NODES),
  localparam int BLK_W     = $clog2(NUM_BLOCKS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [NODE_W-1:0]    req_node,
  input  logic [BLK_W-1:0]     req_block,
  output logic                 fetch_valid,
  output logic [NODE_W-1:0]    fetch_node,
  output logic                 fetch_inv,
  input  logic                 fetch_ack,
  output logic                 inv_valid,
  output logic [NUM_NODES-1:0] inv_mask,
  output logic                 reply_valid,
  output logic [NODE_W-1:0]    reply_node,
  output logic                 err,
  input  logic [BLK_W-1:0]     dbg_block,
  output logic [1:0]           dbg_state,
  output logic [NUM_NODES-1:0] dbg_sharers
);

  localparam logic [NUM_NODES-1:0] ONE = {{(NUM_NODES-1){1'b0}}, 1'b1};

  ctrl_state_e          r_state, w_state_d;
  logic [1:0]           r_req_type, w_req_type_d;
  logic [NODE_W-1:0]    r_req_node, w_req_node_d;
  logic [BLK_W-1:0]     r_req_block, w_req_block_d;
  logic                 r_fetch_valid, w_fetch_valid_d;
  logic [NODE_W-1:0]    r_fetch_node, w_fetch_node_d;
  logic                 r_fetch_inv, w_fetch_inv_d;
  logic                 r_inv_valid, w_inv_valid_d;
  logic [NUM_NODES-1:0] r_inv_mask, w_inv_mask_d;
  logic                 r_reply_valid, w_reply_valid_d;
  logic [NODE_W-1:0]    r_reply_node, w_reply_node_d;
  logic                 r_err, w_err_d;

  logic                 w_wr_en;
  logic [BLK_W-1:0]     w_wr_block;
  logic [1:0]           w_wr_state;
  logic [NUM_NODES-1:0] w_wr_sharers;
  logic [1:0]           w_rd_state;
  logic [NUM_NODES-1:0] w_rd_sharers;
  logic [NODE_W-1:0]    w_rd_owner;
  logic [NUM_NODES-1:0] w_req_bit;
  logic [NUM_NODES-1:0] w_inv_cand;
  logic                 w_illegal;
  logic                 w_excl_other;
  logic                 w_excl_self;

  dir_entry_array #(
    .NUM_NODES (NUM_NODES),
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_entries (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_wr_en      (w_wr_en),
    .i_wr_block   (w_wr_block),
    .i_wr_state   (w_wr_state),
    .i_wr_sharers (w_wr_sharers),
    .i_rd_block   (req_block),
    .o_rd_state   (w_rd_state),
    .o_rd_sharers (w_rd_sharers),
    .o_rd_owner   (w_rd_owner),
    .i_dbg_block  (dbg_block),
    .o_dbg_state  (dbg_state),
    .o_dbg_sharers(dbg_sharers)
  );

  assign w_req_bit    = ONE << req_node;
  assign w_inv_cand   = w_rd_sharers & ~w_req_bit;
  assign w_illegal    = (req_type == REQ_RSVD) || (32'(req_node) >= NUM_NODES);
  assign w_excl_other = (w_rd_state == EXCLUSIVE) && (w_rd_owner != req_node);
  assign w_excl_self  = (w_rd_state == EXCLUSIVE) && (w_rd_owner == req_node);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req_type    <= '0;
      r_req_node    <= '0;
      r_req_block   <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_node  <= '0;
      r_fetch_inv   <= 1'b0;
      r_inv_valid   <= 1'b0;
      r_inv_mask    <= '0;
      r_reply_valid <= 1'b0;
      r_reply_node  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_req_type    <= w_req_type_d;
      r_req_node    <= w_req_node_d;
      r_req_block   <= w_req_block_d;
      r_fetch_valid <= w_fetch_valid_d;
      r_fetch_node  <= w_fetch_node_d;
      r_fetch_inv   <= w_fetch_inv_d;
      r_inv_valid   <= w_inv_valid_d;
      r_inv_mask    <= w_inv_mask_d;
      r_reply_valid <= w_reply_valid_d;
      r_reply_node  <= w_reply_node_d;
      r_err         <= w_err_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_req_type_d    = r_req_type;
    w_req_node_d    = r_req_node;
    w_req_block_d   = r_req_block;
    w_fetch_valid_d = r_fetch_valid;
    w_fetch_node_d  = r_fetch_node;
    w_fetch_inv_d   = r_fetch_inv;
    w_inv_valid_d   = 1'b0;
    w_inv_mask_d    = '0;
    w_reply_valid_d = 1'b0;
    w_reply_node_d  = r_reply_node;
    w_err_d         = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_block      = r_req_block;
    w_wr_state      = w_rd_state;
    w_wr_sharers    = w_rd_sharers;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_req_type_d  = req_type;
          w_req_node_d  = req_node;
          w_req_block_d = req_block;
          w_wr_block    = req_block;
          w_state_d     = ST_DONE;
          if (w_illegal) begin
            w_err_d = 1'b1;
          end else begin
            case (req_type)
              READ_MISS: begin
                if (w_excl_other) begin
                  w_fetch_valid_d = 1'b1;
                  w_fetch_node_d  = w_rd_owner;
                  w_fetch_inv_d   = 1'b0;
                  w_state_d       = ST_FETCH;
                end else begin
                  w_reply_valid_d = 1'b1;
                  w_reply_node_d  = req_node;
                  w_wr_en         = 1'b1;
                  w_wr_state      = SHARED;
                  w_wr_sharers    = (w_rd_state == SHARED) ? (w_rd_sharers | w_req_bit) : w_req_bit;
                end
              end
              WRITE_MISS: begin
                if (w_excl_other) begin
                  w_fetch_valid_d = 1'b1;
                  w_fetch_node_d  = w_rd_owner;
                  w_fetch_inv_d   = 1'b1;
                  w_state_d       = ST_FETCH;
                end else begin
                  w_reply_valid_d = 1'b1;
                  w_reply_node_d  = req_node;
                  // Uncached entries have no sharers, so the candidate mask is empty there.
                  if (!w_excl_self) begin
                    w_inv_valid_d = |w_inv_cand;
                    w_inv_mask_d  = w_inv_cand;
                    w_wr_en       = 1'b1;
                    w_wr_state    = EXCLUSIVE;
                    w_wr_sharers  = w_req_bit;
                  end
                end
              end
              WRITE_BACK: begin
                if (w_excl_self) begin
                  w_wr_en      = 1'b1;
                  w_wr_state   = UNCACHED;
                  w_wr_sharers = '0;
                end else begin
                  w_err_d = 1'b1;
                end
              end
              default: w_err_d = 1'b1;
            endcase
          end
        end
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          w_fetch_valid_d = 1'b0;
          w_fetch_inv_d   = 1'b0;
          w_reply_valid_d = 1'b1;
          w_reply_node_d  = r_req_node;
          w_wr_en         = 1'b1;
          w_wr_block      = r_req_block;
          if (r_req_type == READ_MISS) begin
            w_wr_state   = SHARED;
            w_wr_sharers = (ONE << r_fetch_node) | (ONE << r_req_node);
          end else begin
            w_wr_state   = EXCLUSIVE;
            w_wr_sharers = ONE << r_req_node;
          end
          w_state_d = ST_DONE;
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign fetch_valid = r_fetch_valid;
  assign fetch_node  = r_fetch_node;
  assign fetch_inv   = r_fetch_inv;
  assign inv_valid   = r_inv_valid;
  assign inv_mask    = r_inv_mask;
  assign reply_valid = r_reply_valid;
  assign reply_node  = r_reply_node;
  assign err         = r_err;

endmodule

// File: tb/tb_dir_controller.sv
// tb/tb_dir_controller.sv - directed and randomized bench for dir_controller
module tb_dir_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_type;
  logic [1:0] req_node;
  logic [1:0] req_block;
  logic       fetch_valid;
  logic [1:0] fetch_node;
  logic       fetch_inv;
  logic       fetch_ack;
  logic       inv_valid;
  logic [3:0] inv_mask;
  logic       reply_valid;
  logic [1:0] reply_node;
  logic       err;
  logic [1:0] dbg_block;
  logic [1:0] dbg_state;
  logic [3:0] dbg_sharers;

  int n_checks = 0;
  int n_errors = 0;

  // Reference directory: state 0=U 1=S 2=E, sharers as a plain bit set.
  int         m_st [4];
  logic [3:0] m_sh [4];

  dir_controller #(.NUM_NODES(4), .NUM_BLOCKS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_node   (req_node),
    .req_block  (req_block),
    .fetch_valid(fetch_valid),
    .fetch_node (fetch_node),
    .fetch_inv  (fetch_inv),
    .fetch_ack  (fetch_ack),
    .inv_valid  (inv_valid),
    .inv_mask   (inv_mask),
    .reply_valid(reply_valid),
    .reply_node (reply_node),
    .err        (err),
    .dbg_block  (dbg_block),
    .dbg_state  (dbg_state),
    .dbg_sharers(dbg_sharers)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int owner_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_entry(input string tag, input int b);
    dbg_block = 2'(b);
    #1;
    chk({tag, "_state"}, 32'(dbg_state), 32'(m_st[b]));
    chk({tag, "_sharers"}, 32'(dbg_sharers), 32'(m_sh[b]));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0;
      m_sh[i] = 4'b0000;
    end
  endtask

  task automatic do_req(input int t, input int n, input int b, input int ack_dly);
    int         st, o, k;
    logic [3:0] sh, nbit, inv;
    bit         fetch, rep, e;
    st = m_st[b];
    sh = m_sh[b];
    o = owner_of(sh);
    nbit = 4'b0001 << n;
    fetch = 0; rep = 0; e = 0; inv = 4'b0000;
    case (t)
      0: begin
        if (st == 2 && o != n) begin fetch = 1; sh = (4'b0001 << o) | nbit; end
        else begin rep = 1; sh = (st == 1) ? (sh | nbit) : nbit; end
        st = 1;
      end
      1: begin
        if (st == 2 && o != n) begin fetch = 1; sh = nbit; end
        else if (st == 2) rep = 1;
        else begin inv = sh & ~nbit; rep = 1; st = 2; sh = nbit; end
      end
      2: begin
        if (st == 2 && o == n) begin st = 0; sh = 4'b0000; end
        else e = 1;
      end
      default: e = 1;
    endcase

    @(negedge clock);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clock); k++; end
    chk("ready_before_req", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_type  = 2'(t);
    req_node  = 2'(n);
    req_block = 2'(b);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    if (fetch) begin
      for (int c = 0; c < ack_dly; c++) begin
        chk("fetch_valid_held", 32'(fetch_valid), 1);
        chk("fetch_node", 32'(fetch_node), 32'(o));
        chk("fetch_inv", 32'(fetch_inv), 32'(t == 1));
        chk("ready_low_fetch", 32'(req_ready), 0);
        chk("no_reply_in_fetch", 32'(reply_valid), 0);
        @(negedge clock);
      end
      chk("fetch_valid_at_ack", 32'(fetch_valid), 1);
      fetch_ack = 1'b1;
      @(posedge clock);
      #1 fetch_ack = 1'b0;
      @(negedge clock);
      chk("fetch_valid_fall", 32'(fetch_valid), 0);
      chk("reply_after_ack", 32'(reply_valid), 1);
      chk("reply_node_fetch", 32'(reply_node), 32'(n));
      chk("err_fetch", 32'(err), 0);
      chk("ready_low_done", 32'(req_ready), 0);
    end else begin
      chk("reply_valid", 32'(reply_valid), 32'(rep));
      if (rep) chk("reply_node", 32'(reply_node), 32'(n));
      chk("inv_valid", 32'(inv_valid), 32'(inv != 0));
      if (inv != 0) chk("inv_mask", 32'(inv_mask), 32'(inv));
      chk("err", 32'(err), 32'(e));
      chk("no_fetch", 32'(fetch_valid), 0);
      chk("ready_low_done", 32'(req_ready), 0);
    end
    @(negedge clock);
    chk("pulse_reply_clear", 32'(reply_valid), 0);
    chk("pulse_inv_clear", 32'(inv_valid), 0);
    chk("pulse_err_clear", 32'(err), 0);
    chk("ready_back", 32'(req_ready), 1);
    m_st[b] = st;
    m_sh[b] = sh;
    chk_entry("entry", b);
    chk_entry("other", int'($urandom_range(0, 3)));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_type = 2'b00;
    req_node = 2'b00;
    req_block = 2'b00;
    fetch_ack = 1'b0;
    dbg_block = 2'b00;
    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_reply_valid", 32'(reply_valid), 0);
    chk("rst_inv", 32'({inv_valid, inv_mask}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_nodes", 32'({fetch_node, reply_node, fetch_inv}), 0);
    for (int i = 0; i < 4; i++) chk_entry("rst", i);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 1);

    // 1: read miss into an uncached block
    do_req(0, 2, 1, 0);
    dbg_block = 2'd1; #1;
    chk("t1_state", 32'(dbg_state), 32'h1);
    chk("t1_sharers", 32'(dbg_sharers), 32'h4);

    // 2: two readers, then a write miss by one of them
    do_req(0, 0, 0, 0);
    do_req(0, 3, 0, 0);
    do_req(0, 3, 0, 0);
    do_req(1, 3, 0, 0);
    dbg_block = 2'd0; #1;
    chk("t2_state", 32'(dbg_state), 32'h2);
    chk("t2_sharers", 32'(dbg_sharers), 32'h8);

    // 3: read miss to a block owned elsewhere, ack after 5 cycles
    do_req(1, 1, 2, 0);
    do_req(0, 0, 2, 5);
    dbg_block = 2'd2; #1;
    chk("t3_state", 32'(dbg_state), 32'h1);
    chk("t3_sharers", 32'(dbg_sharers), 32'h3);

    // 4: write miss to a block owned elsewhere
    do_req(1, 1, 2, 0);
    do_req(1, 2, 2, 2);
    dbg_block = 2'd2; #1;
    chk("t4_state", 32'(dbg_state), 32'h2);
    chk("t4_sharers", 32'(dbg_sharers), 32'h4);

    // 5: illegal write-backs, reserved type, owner write-back, owner self-misses
    do_req(2, 0, 2, 0);
    do_req(3, 1, 2, 0);
    do_req(1, 2, 2, 0);
    do_req(2, 2, 2, 0);
    dbg_block = 2'd2; #1;
    chk("t5_state", 32'(dbg_state), 32'h0);
    chk("t5_sharers", 32'(dbg_sharers), 32'h0);
    do_req(2, 1, 2, 0);
    do_req(1, 3, 3, 0);
    do_req(0, 3, 3, 0);

    // 6: reset while a fetch is outstanding
    do_req(1, 3, 3, 0);
    @(negedge clock);
    req_valid = 1'b1;
    req_type  = 2'b00;
    req_node  = 2'd1;
    req_block = 2'd3;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("t6_in_fetch", 32'(fetch_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_drop", 32'(fetch_valid), 0);
    model_clear();
    for (int i = 0; i < 4; i++) chk_entry("t6_cleared", i);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_ready", 32'(req_ready), 1);
    fetch_ack = 1'b1;
    @(negedge clock);
    fetch_ack = 1'b0;
    chk("t6_late_ack_err", 32'(err), 0);
    chk("t6_late_ack_reply", 32'(reply_valid), 0);
    chk("t6_late_ack_fetch", 32'(fetch_valid), 0);
    chk_entry("t6_after_ack", 3);

    // Randomized traffic against the reference directory
    for (int i = 0; i < 200; i++) begin
      do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dir_controller.md
Name: dir_controller

Overview:
- Parametrised successor to the two-node, single-block directory FSM.
- Tracks MSI-style directory state (Uncached/Shared/Exclusive) and a full sharer bit-vector for NUM_BLOCKS memory blocks across NUM_NODES caches.
- Accepts one coherence message at a time through a valid/ready handshake and issues fetch, invalidate and data-value-reply messages.
- Sits between the cache-block controllers and memory, and drives per-block state to the board displays through a debug read port.

Parameters:
- NUM_NODES, 4, number of caches; width of sharer vectors (2..16).
- NUM_BLOCKS, 4, number of directory entries (power of two, >=2).
- NODE_W, $clog2(NUM_NODES), width of node IDs (localparam).
- BLK_W, $clog2(NUM_BLOCKS), width of block index (localparam).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the controller accepts a request this cycle; high only in IDLE.
- req_type  in  2  00 READ_MISS, 01 WRITE_MISS, 10 WRITE_BACK, 11 reserved.
- req_node  in  NODE_W  requesting node.
- req_block  in  BLK_W  target block.
- fetch_valid  out  1  fetch request to the owner; held until acknowledged.
- fetch_node  out  NODE_W  owner node being fetched.
- fetch_inv  out  1  owner must also invalidate its copy (write-miss fetch).
- fetch_ack  in  1  owner has written back its data.
- inv_valid  out  1  one-cycle invalidate pulse.
- inv_mask  out  NUM_NODES  nodes to invalidate; valid when inv_valid is high.
- reply_valid  out  1  one-cycle data-value-reply pulse.
- reply_node  out  NODE_W  destination of the reply.
- err  out  1  one-cycle pulse for an illegal or ignored request.
- dbg_block  in  BLK_W  block selected for the debug port.
- dbg_state  out  2  state of dbg_block: 00 Uncached, 01 Shared, 10 Exclusive (combinational read).
- dbg_sharers  out  NUM_NODES  sharer vector of dbg_block (combinational read).

Behaviour:
- Reset:
  - All entries go to Uncached with sharers 0.
  - Controller FSM goes to IDLE.
  - fetch_valid, fetch_inv, inv_valid, reply_valid and err are 0; fetch_node, reply_node and inv_mask are 0.
  - req_ready is 1 from the first cycle after reset is released.
- Handshake:
  - A request is accepted on a rising edge where req_valid and req_ready are both high; the request fields are latched at that edge.
  - req_ready is low from the cycle after acceptance until the FSM returns to IDLE.
- Controller FSM has three states: IDLE, FETCH, DONE.
  - IDLE, on accept: evaluate the request against the selected entry.
    - If no fetch is needed: update the entry, register the outputs, go to DONE. Outputs are visible exactly 1 cycle after the accept edge.
    - If a fetch is needed: go to FETCH.
  - FETCH:
    - Assert fetch_valid with fetch_node = owner and fetch_inv as specified below; hold all three stable.
    - On a sampled fetch_ack: update the entry, pulse reply_valid in the next cycle, go to DONE.
    - fetch_valid first rises 1 cycle after accept and falls on the edge where fetch_ack is sampled.
  - DONE: one cycle carrying the pulses, then return to IDLE. Minimum request-to-request spacing is therefore 2 cycles.
  - fetch_ack outside FETCH is ignored and does not pulse err.
- Transitions, where o = owner (the single set bit of sharers) and n = req_node:
  - READ_MISS, Uncached: reply to n; state becomes Shared; sharers = {n}.
  - READ_MISS, Shared: reply to n; sharers |= {n}, which is idempotent if n is already set.
  - READ_MISS, Exclusive, o != n: fetch o with fetch_inv = 0; after the ack, reply to n; state becomes Shared; sharers = {o, n}.
  - READ_MISS, Exclusive, o == n: reply to n; state becomes Shared; sharers = {n}; no fetch.
  - WRITE_MISS, Uncached: reply to n; state becomes Exclusive; sharers = {n}.
  - WRITE_MISS, Shared:
    - inv_mask = sharers & ~{n}; inv_valid pulses only if the mask is nonzero.
    - Reply to n in the same cycle as the invalidate; state becomes Exclusive; sharers = {n}.
  - WRITE_MISS, Exclusive, o != n: fetch o with fetch_inv = 1; after the ack, reply to n; sharers = {n}; state stays Exclusive.
  - WRITE_MISS, Exclusive, o == n: reply only; no state change.
  - WRITE_BACK from n == o in Exclusive: state becomes Uncached; sharers = 0; no reply.
  - WRITE_BACK in any other case: no state change; err pulses in DONE.
  - req_type 11 or req_node >= NUM_NODES: no state change; err pulses in DONE.
- Only the addressed entry changes; all other entries hold.
- Reset asserted mid-operation (including in FETCH) abandons the transaction and clears everything as above. Outstanding fetches are not completed.
- Invariants:
  - Exclusive implies exactly one sharer bit set.
  - Uncached implies sharers == 0.
  - Shared implies at least one sharer bit set.

Decomposition:
- Shared package dir_pkg holds:
  - the state encodings (UNCACHED = 2'b00, SHARED = 2'b01, EXCLUSIVE = 2'b10);
  - the request-type encodings (READ_MISS = 2'b00, WRITE_MISS = 2'b01, WRITE_BACK = 2'b10).
- The cache-block FSM reuses these encodings so both feed the same 7-segment I/S/M decoder.
- One sub-module, dir_entry_array: NUM_BLOCKS entries of {state, sharers}, with one write port and two combinational read ports (request lookup and debug).
- Also in dir_entry_array: a onehot-to-index helper that computes the owner from the sharer vector.

Test Plan:
1. Reset, then READ_MISS node 2, block 1 -> reply_valid one cycle after accept with reply_node = 2; dbg_block = 1 gives state 01 and sharers 0100.
2. READ_MISS from nodes 0 and 3 on block 0, then WRITE_MISS node 3 on block 0 -> inv_valid with inv_mask = 0001 and reply_node = 3 in the same cycle; state 10, sharers 1000.
3. Block 2 Exclusive at node 1, then READ_MISS node 0 -> fetch_valid with fetch_node = 1 and fetch_inv = 0, held 5 cycles until fetch_ack; reply to node 0 the cycle after; state 01, sharers 0011; req_ready low throughout.
4. Block 2 Exclusive at node 1, then WRITE_MISS node 2 -> fetch_inv = 1; after the ack, reply to node 2; sharers 0100; state 10.
5. WRITE_BACK from a non-owner and req_type 11 -> err pulse, state unchanged. WRITE_BACK from the owner -> state 00, sharers 0000, no reply.
6. Assert reset while in FETCH -> fetch_valid drops asynchronously; all entries read 00/0000; req_ready = 1 after release; a fetch_ack arriving late is ignored.
